rf_wb_unit: RTL

Writeback merge unit that drives the single write port of the integer register file (RFWrite / rd / rd_WriteData). It accepts results from three producers: the in-order pipeline, the multi-cycle mul/div unit and the load unit. It selects one result per cycle and registers it onto the register-file write port. It also keeps a pending-write scoreboard so the issue stage can stall on registers still owned by a long-latency producer.

---
 rtl/rf_wb_unit_pkg.sv | 45 ++++
 rtl/rf_wb_unit_if.sv | 44 ++++
 rtl/rf_wb_scoreboard.sv | 40 ++++
 rtl/rf_wb_unit.sv | 119 +++++++++++
 4 files changed

// File: rtl/rf_wb_unit_pkg.sv
// Shared types for the register-file writeback merge unit.
// Fallback definitions of the CPU_Parameter.vh widths so this slice elaborates standalone.
`ifndef WORD
`define WORD 32
`endif
`ifndef REG_LOG
`define REG_LOG 5
`endif
`ifndef NREG
`define NREG 32
`endif

package rf_wb_unit_pkg;

   localparam int WORD_W   = `WORD;
   localparam int RLOG_W   = `REG_LOG;
   localparam int NREG_DEF = `NREG;

   typedef logic [`WORD-1:0]    word_t;
   typedef logic [`REG_LOG-1:0] reg_idx_t;

   typedef enum logic {
      RR_PREF_B = 1'b0,
      RR_PREF_C = 1'b1
   } rr_state_t;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_A    = 2'd1,
      SRC_B    = 2'd2,
      SRC_C    = 2'd3
   } wb_src_t;

   typedef struct packed {
      logic     valid;
      reg_idx_t rd;
      word_t    data;
   } wb_req_t;

   // r0 is hardwired, so a result aimed at it never raises the write enable.
   function automatic logic writes_rf(input wb_req_t req);
      return req.valid && (req.rd != '0);
   endfunction

endpackage

// File: rtl/rf_wb_unit_if.sv
// Producer / issue / register-file-port bundle of the writeback merge unit.
interface rf_wb_unit_if
   import rf_wb_unit_pkg::*;
#(
   parameter int NREG = NREG_DEF
) ();

   logic            a_valid;
   reg_idx_t        a_rd;
   word_t           a_data;
   logic            b_valid;
   logic            b_ready;
   reg_idx_t        b_rd;
   word_t           b_data;
   logic            c_valid;
   logic            c_ready;
   reg_idx_t        c_rd;
   word_t           c_data;
   logic            iss_valid;
   reg_idx_t        iss_rd;
   logic [NREG-1:0] pending;
   logic            RFWrite;
   reg_idx_t        rd;
   word_t           rd_WriteData;

   modport master (
      output a_valid, a_rd, a_data,
      output b_valid, b_rd, b_data,
      output c_valid, c_rd, c_data,
      output iss_valid, iss_rd,
      input  b_ready, c_ready, pending,
      input  RFWrite, rd, rd_WriteData
   );

   modport slave (
      input  a_valid, a_rd, a_data,
      input  b_valid, b_rd, b_data,
      input  c_valid, c_rd, c_data,
      input  iss_valid, iss_rd,
      output b_ready, c_ready, pending,
      output RFWrite, rd, rd_WriteData
   );

endinterface

// File: rtl/rf_wb_scoreboard.sv
// Pending-write bitmap: one bit per register still owned by the mul/div or load unit.
module rf_wb_scoreboard
   import rf_wb_unit_pkg::*;
#(
   parameter int NREG = NREG_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            set_en,
   input  reg_idx_t        set_rd,
   input  logic            clr_en,
   input  reg_idx_t        clr_rd,
   output logic [NREG-1:0] pending
);

   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] clr_mask;
   logic [NREG-1:0] pend_d;

   // Set is applied after clear: a fresh issue supersedes the result retiring this cycle.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      for (int i = 1; i < NREG; i++) begin
         set_mask[i] = set_en && (set_rd == reg_idx_t'(i));
         clr_mask[i] = clr_en && (clr_rd == reg_idx_t'(i));
      end
      pend_d    = (pending & ~clr_mask) | set_mask;
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
      end else begin
         pending <= pend_d;
      end
   end

endmodule

// File: rtl/rf_wb_unit.sv
// Writeback merge: A (pipeline) has absolute priority, B (mul/div) and C (load) share
// the leftover slots round-robin; the winner is registered onto the register-file write port.
//
// state     | meaning
// RR_PREF_B | mul/div preferred on the next free slot (reset, or after a C transfer)
// RR_PREF_C | load unit preferred on the next free slot (after a B transfer)
module rf_wb_unit
   import rf_wb_unit_pkg::*;
#(
   parameter int NREG = NREG_DEF
) (
   input logic         clk,
   input logic         rst_n,
   rf_wb_unit_if.slave wb
);

   rr_state_t       rr_q;
   rr_state_t       rr_d;
   logic            b_ready_c;
   logic            c_ready_c;
   logic            b_xfer;
   logic            c_xfer;
   wb_src_t         win_src;
   wb_req_t         win;
   logic            rf_write_q;
   reg_idx_t        rd_q;
   word_t           data_q;
   logic [NREG-1:0] pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q <= RR_PREF_B;
      end else begin
         rr_q <= rr_d;
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (b_xfer) begin
         rr_d = RR_PREF_C;
      end else if (c_xfer) begin
         rr_d = RR_PREF_B;
      end
   end

   // Ready never looks at the output register, so producers see a purely combinational grant.
   always_comb begin
      b_ready_c = 1'b0;
      c_ready_c = 1'b0;
      if (!wb.a_valid) begin
         case (rr_q)
            RR_PREF_B: begin
               b_ready_c = wb.b_valid;
               c_ready_c = !wb.b_valid;
            end
            RR_PREF_C: begin
               c_ready_c = wb.c_valid;
               b_ready_c = !wb.c_valid;
            end
         endcase
      end
      b_xfer  = wb.b_valid && b_ready_c;
      c_xfer  = wb.c_valid && c_ready_c;
      win_src = SRC_NONE;
      if (wb.a_valid) begin
         win_src = SRC_A;
      end else if (b_xfer) begin
         win_src = SRC_B;
      end else if (c_xfer) begin
         win_src = SRC_C;
      end
   end

   always_comb begin
      win = '0;
      unique case (win_src)
         SRC_A:    win = '{valid: 1'b1, rd: wb.a_rd, data: wb.a_data};
         SRC_B:    win = '{valid: 1'b1, rd: wb.b_rd, data: wb.b_data};
         SRC_C:    win = '{valid: 1'b1, rd: wb.c_rd, data: wb.c_data};
         SRC_NONE: win = '0;
      endcase
   end

   // Address and data hold when idle so the write port stays quiet across the negedge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_write_q <= 1'b0;
         rd_q       <= '0;
         data_q     <= '0;
      end else begin
         rf_write_q <= writes_rf(win);
         if (win.valid) begin
            rd_q   <= win.rd;
            data_q <= win.data;
         end
      end
   end

   rf_wb_scoreboard #(
      .NREG (NREG)
   ) u_scoreboard (
      .clk     (clk),
      .rst_n   (rst_n),
      .set_en  (wb.iss_valid),
      .set_rd  (wb.iss_rd),
      .clr_en  (b_xfer || c_xfer),
      .clr_rd  (win.rd),
      .pending (pending)
   );

   assign wb.b_ready      = b_ready_c;
   assign wb.c_ready      = c_ready_c;
   assign wb.pending      = pending;
   assign wb.RFWrite      = rf_write_q;
   assign wb.rd           = rd_q;
   assign wb.rd_WriteData = data_q;

endmodule
